cpu_lsu: RTL and testbench

- Load/store unit: consumes the memory command fields the CPU control decoder produces (cmd, be_mem, sx_cntl) and performs the data-memory transaction.
- Drives a req/ack data bus and stalls the pipeline while a transaction is outstanding.
- Formats load data (lane select, sign/zero extension) and store data (lane replication, byte enables).
- Sits between the execute stage (address from ALU, store data from register file) and the data memory.

---
 rtl/cpu_lsu_if.sv | 24 ++
 rtl/cpu_lsu.sv | 137 +++++++++++++
 tb/tb_cpu_lsu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_lsu_if.sv
// Data-memory bus between the load/store unit and memory.
// master: m_req/m_we/m_addr/m_be/m_wdata out; m_ack/m_err/m_rdata in.
interface cpu_lsu_if #(
  parameter int AW = 32
) ();
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;
  logic [31:0]   m_wdata;
  logic          m_ack;
  logic          m_err;
  logic [31:0]   m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata,
    input  m_ack, m_err, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata,
    output m_ack, m_err, m_rdata
  );
endinterface

// File: rtl/cpu_lsu.sv
// Load/store unit: cmd/be_mem/sx_cntl/addr/wdata in; stall, ld_data,
// ld_vld, misalign, bus_err out; data bus via cpu_lsu_if master.
module cpu_lsu #(
  parameter int AW         = 32,
  parameter int TMO_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [1:0]    be_mem,
  input  logic [2:0]    sx_cntl,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic [31:0]   ld_data,
  output logic          ld_vld,
  output logic          misalign,
  output logic          bus_err,
  cpu_lsu_if.master     bus
);

  localparam int CW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} st_t;

  st_t         st, st_nx;
  logic [CW-1:0] cnt;
  logic [1:0]  lane;
  logic [1:0]  fsz;
  logic        sgn;

  logic        acc, mis, tmo;
  logic        is_h, is_b;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [31:0] sh;
  logic [15:0] hw;
  logic [31:0] fmt;

  assign bus.m_req = (st == WAIT);

  always_comb begin
    acc   = (st != WAIT) && cmd[1];
    is_h  = (be_mem == 2'b01);
    is_b  = (be_mem == 2'b10);
    mis   = 1'b0;
    be_nx = 4'b1111;
    wd_nx = wdata;
    unique case (1'b1)
      is_h: begin
        mis   = addr[0];
        be_nx = addr[1] ? 4'b1100 : 4'b0011;
        wd_nx = {2{wdata[15:0]}};
      end
      is_b: begin
        be_nx = 4'b0001 << addr[1:0];
        wd_nx = {4{wdata[7:0]}};
      end
      default: mis = |addr[1:0];
    endcase
    stall = (st == WAIT) || acc;
    tmo   = (cnt == CW'(TMO_CYCLES - 1));
  end

  // Lane/size/sign latched at accept so held inputs can change.
  always_comb begin
    sh  = bus.m_rdata >> {lane, 3'b000};
    hw  = lane[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    fmt = bus.m_rdata;
    unique case (fsz)
      2'b10:   fmt = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   fmt = {{16{sgn & hw[15]}}, hw};
      default: fmt = bus.m_rdata;
    endcase
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      WAIT:    if (bus.m_ack || tmo) st_nx = DONE;
      default: begin
        if (acc) st_nx = mis ? DONE : WAIT;
        else     st_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      cnt         <= '0;
      lane        <= '0;
      fsz         <= '0;
      sgn         <= 1'b0;
      ld_data     <= '0;
      ld_vld      <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_be    <= '0;
      bus.m_wdata <= '0;
    end else begin
      st       <= st_nx;
      ld_vld   <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (acc && mis) begin
        misalign <= 1'b1;
      end else if (acc) begin
        bus.m_we    <= ~cmd[0];
        bus.m_addr  <= {addr[AW-1:2], 2'b00};
        bus.m_be    <= be_nx;
        bus.m_wdata <= wd_nx;
        lane        <= addr[1:0];
        fsz         <= sx_cntl[1:0];
        sgn         <= sx_cntl[2];
        cnt         <= '0;
      end
      if (st == WAIT) begin
        cnt <= cnt + CW'(1);
        if (bus.m_ack) begin
          if (bus.m_err) begin
            bus_err <= 1'b1;
          end else if (!bus.m_we) begin
            ld_vld  <= 1'b1;
            ld_data <= fmt;
          end
        end else if (tmo) begin
          bus_err <= 1'b1;
          ld_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// Randomized self-checking bench for cpu_lsu against a
// transaction-level model; checks outputs every cycle.
module tb_cpu_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd, be_mem;
  logic [2:0]  sx_cntl;
  logic [31:0] addr, wdata;
  logic        stall, ld_vld, misalign, bus_err;
  logic [31:0] ld_data;

  cpu_lsu_if #(.AW(32)) bus ();

  cpu_lsu #(.AW(32), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .be_mem(be_mem),
    .sx_cntl(sx_cntl), .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .ld_vld(ld_vld),
    .misalign(misalign), .bus_err(bus_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_vld, e_mis, e_err, e_zero;
  logic        ew;
  logic [31:0] ea, ewd, m_ld;
  logic [3:0]  eb;
  logic        p_vld, p_mis, p_err, p_ldw;
  logic [31:0] p_ld;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", nm, a, e, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    case (sz)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_mis(logic [1:0] sz, logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] f_be(logic [1:0] sz, logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] f_wd(logic [1:0] sz, logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] f_ld(logic [1:0] sz, logic sg,
                                       logic [31:0] a, logic [31:0] rd);
    logic [63:0] v, mask;
    int n = nbytes(sz);
    v    = {32'd0, rd} >> (8 * a[1:0]);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("m_req", 32'(bus.m_req), 32'(e_req));
      chk("ld_vld", 32'(ld_vld), 32'(e_vld));
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("ld_data", ld_data, m_ld);
      if (e_req) begin
        chk("m_we", 32'(bus.m_we), 32'(ew));
        chk("m_addr", bus.m_addr, ea);
        chk("m_be", 32'(bus.m_be), 32'(eb));
        chk("m_wdata", bus.m_wdata, ewd);
      end
      if (e_zero) begin
        chk("rst_we", 32'(bus.m_we), 32'd0);
        chk("rst_addr", bus.m_addr, 32'd0);
        chk("rst_be", 32'(bus.m_be), 32'd0);
        chk("rst_wdata", bus.m_wdata, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cmd         = 2'b00;
    be_mem      = 2'($urandom);
    sx_cntl     = 3'($urandom);
    addr        = $urandom;
    wdata       = $urandom;
    bus.m_ack   = 1'b0;
    bus.m_err   = 1'b0;
    bus.m_rdata = $urandom;
    e_stall = 1'b0;
    e_req   = 1'b0;
    e_vld   = p_vld;
    e_mis   = p_mis;
    e_err   = p_err;
    if (p_ldw) m_ld = p_ld;
    p_vld = 1'b0; p_mis = 1'b0; p_err = 1'b0; p_ldw = 1'b0;
  endtask

  task automatic txn(logic [1:0] c, logic [1:0] sz, logic sg,
                     logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                     int dly, logic er);
    step();
    cmd = c; be_mem = sz; sx_cntl = {sg, sz}; addr = a; wdata = wd;
    e_stall = 1'b1;
    if (is_mis(sz, a)) begin
      p_mis = 1'b1;
      return;
    end
    e_zero = 1'b0;
    ew  = (c == 2'b10);
    ea  = {a[31:2], 2'b00};
    eb  = f_be(sz, a);
    ewd = f_wd(sz, wd);
    for (int k = 0; k < TMO; k++) begin
      step();
      cmd = 2'($urandom);
      e_stall = 1'b1;
      e_req   = 1'b1;
      if (k == dly) begin
        bus.m_ack = 1'b1; bus.m_err = er; bus.m_rdata = rd;
        p_err = er;
        p_vld = !ew && !er;
        if (p_vld) begin
          p_ldw = 1'b1;
          p_ld  = f_ld(sz, sg, a, rd);
        end
        return;
      end
    end
    p_err = 1'b1;
    p_ldw = 1'b1;
    p_ld  = 32'd0;
  endtask

  initial begin
    int r, dly;
    logic [1:0] c, sz;
    logic [31:0] a;
    rst_n = 1'b0;
    cmd = 2'b00; be_mem = 2'b00; sx_cntl = 3'b000;
    addr = '0; wdata = '0;
    bus.m_ack = 1'b0; bus.m_err = 1'b0; bus.m_rdata = '0;
    p_vld = 1'b0; p_mis = 1'b0; p_err = 1'b0; p_ldw = 1'b0; p_ld = '0;
    m_ld = '0; e_zero = 1'b1;
    ew = 1'b0; ea = '0; eb = '0; ewd = '0;
    step();
    step();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step();

    chk("pin_ld_w", f_ld(2'b00, 1'b0, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    chk("pin_be_w", 32'(f_be(2'b00, 32'h100)), 32'hF);
    chk("pin_ld_bs", f_ld(2'b10, 1'b1, 32'h203, 32'h80123456), 32'hFFFFFF80);
    chk("pin_ld_bz", f_ld(2'b10, 1'b0, 32'h203, 32'h80123456), 32'h00000080);
    chk("pin_be_b", 32'(f_be(2'b10, 32'h203)), 32'h8);
    chk("pin_ld_hs", f_ld(2'b01, 1'b1, 32'h302, 32'hABCD1234), 32'hFFFFABCD);
    chk("pin_ld_hz", f_ld(2'b01, 1'b0, 32'h302, 32'hABCD1234), 32'h0000ABCD);
    chk("pin_be_sb", 32'(f_be(2'b10, 32'h401)), 32'h2);
    chk("pin_wd_sb", f_wd(2'b10, 32'h000000A5), 32'hA5A5A5A5);
    chk("pin_mis", 32'(is_mis(2'b00, 32'h502)), 32'd1);

    txn(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    step();
    txn(2'b11, 2'b10, 1'b1, 32'h203, 32'h0, 32'h80123456, 0, 1'b0);
    txn(2'b11, 2'b10, 1'b0, 32'h203, 32'h0, 32'h80123456, 1, 1'b0);
    txn(2'b11, 2'b01, 1'b1, 32'h302, 32'h0, 32'hABCD1234, 0, 1'b0);
    txn(2'b11, 2'b01, 1'b0, 32'h302, 32'h0, 32'hABCD1234, 2, 1'b0);
    txn(2'b10, 2'b10, 1'b0, 32'h401, 32'hA5, 32'h0, 5, 1'b0);
    step();
    txn(2'b11, 2'b00, 1'b0, 32'h502, 32'h0, 32'h0, 0, 1'b0);
    step();
    txn(2'b11, 2'b00, 1'b0, 32'h600, 32'h0, 32'h0, 99, 1'b0);
    step();
    txn(2'b11, 2'b00, 1'b0, 32'h610, 32'h0, 32'h12345678, 1, 1'b1);
    txn(2'b10, 2'b01, 1'b0, 32'h702, 32'h1234BEEF, 32'h0, 0, 1'b0);
    txn(2'b11, 2'b00, 1'b0, 32'h704, 32'h0, 32'hCAFEF00D, 0, 1'b0);

    step();
    cmd = 2'b11; be_mem = 2'b00; sx_cntl = 3'b000; addr = 32'h800;
    e_stall = 1'b1;
    e_zero = 1'b0; ew = 1'b0; ea = 32'h800; eb = 4'hF; ewd = wdata;
    step();
    e_stall = 1'b1; e_req = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_ld = 32'd0; e_zero = 1'b1;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h55AA55AA;
    step();
    step();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        step();
        cmd = r[0] ? 2'b01 : 2'b00;
      end else begin
        c  = $urandom_range(0, 1) ? 2'b11 : 2'b10;
        sz = 2'($urandom);
        a  = $urandom;
        if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
        dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2)
                                          : $urandom_range(0, 2);
        txn(c, sz, 1'($urandom), a, $urandom, $urandom, dly,
            $urandom_range(0, 7) == 0);
      end
    end
    step();
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
